// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a 16x8 synchronous RAM.
// Optional one-cycle RAM clear after reset; registered Moore outputs.
module ram_arbiter #(
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       wr_a,
  input  logic       wr_b,
  input  logic [3:0] addr_a,
  input  logic [3:0] addr_b,
  input  logic [7:0] wdata_a,
  input  logic [7:0] wdata_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b,
  output logic       busy,
  output logic       ram_rst,
  output logic       ram_we,
  output logic       ram_re,
  output logic [3:0] ram_wr_add,
  output logic [3:0] ram_rd_add,
  output logic [7:0] ram_datain,
  input  logic [7:0] ram_dataout
);

  // state | meaning
  // INIT  | post-reset, optional RAM clear pulse
  // IDLE  | wait for a request, arbitrate
  // WRITE | RAM write enable asserted
  // READ  | RAM read enable asserted
  // RCAP  | RAM read data available, captured on exit
  // DONE  | ack pulse to the winner
  typedef enum logic [2:0] {INIT, IDLE, WRITE, READ, RCAP, DONE} state_t;

  state_t     state;
  logic       prio;       // 0 = A has priority, 1 = B
  logic       sel;        // latched winner, 0 = A, 1 = B
  logic [3:0] lat_addr;
  logic [7:0] lat_wdata;

  logic       grant_b;
  logic       win_wr;
  logic [3:0] win_addr;
  logic [7:0] win_wdata;

  assign grant_b   = req_b & (~req_a | prio);
  assign win_wr    = grant_b ? wr_b    : wr_a;
  assign win_addr  = grant_b ? addr_b  : addr_a;
  assign win_wdata = grant_b ? wdata_b : wdata_a;

  assign ram_wr_add = lat_addr;
  assign ram_rd_add = lat_addr;
  assign ram_datain = lat_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= INIT;
      prio      <= 1'b0;
      sel       <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      rdata_a   <= '0;
      rdata_b   <= '0;
      busy      <= 1'b1;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
      ram_rst   <= INIT_CLEAR;
    end else begin
      ack_a   <= 1'b0;
      ack_b   <= 1'b0;
      ram_we  <= 1'b0;
      ram_re  <= 1'b0;
      ram_rst <= 1'b0;
      case (state)
        INIT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        IDLE: begin
          if (req_a || req_b) begin
            sel       <= grant_b;
            prio      <= ~grant_b;
            lat_addr  <= win_addr;
            lat_wdata <= win_wdata;
            busy      <= 1'b1;
            if (win_wr) begin
              state  <= WRITE;
              ram_we <= 1'b1;
            end else begin
              state  <= READ;
              ram_re <= 1'b1;
            end
          end
        end
        WRITE: begin
          state <= DONE;
          ack_a <= ~sel;
          ack_b <= sel;
        end
        READ: begin
          state <= RCAP;
        end
        RCAP: begin
          state <= DONE;
          ack_a <= ~sel;
          ack_b <= sel;
          if (sel) rdata_b <= ram_dataout;
          else     rdata_a <= ram_dataout;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter INIT_CLEAR, default 1; 1 = issue a one-cycle RAM clear after reset, 0 = skip the clear.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous reset, active-low (0 = reset).
REQ-005 req_a / req_b  input  1  requester A/B transaction request, level, held until ack.
REQ-006 wr_a / wr_b  input  1  1 = write, 0 = read; stable while req high.
REQ-007 addr_a / addr_b  input  4  RAM word address; stable while req high.
REQ-008 wdata_a / wdata_b  input  8  write data; stable while req high.
REQ-009 ack_a / ack_b  output  1  one-cycle completion pulse.
REQ-010 rdata_a / rdata_b  output  8  read result, valid in the ack cycle, held until the next read completion for that requester.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 ram_rst, ram_we, ram_re  output  1  drive the 16x8 RAM's sync active-high reset, write enable and read enable.
REQ-013 ram_wr_add, ram_rd_add  output  4  RAM addresses; ram_datain  output  8.
REQ-014 ram_dataout  input  8  RAM registered read data (updates one edge after ram_re).

Function
REQ-015 FSM states: INIT, IDLE, WRITE, READ, RCAP, DONE; all ram_* and ack outputs are Moore decodes of the state and latched fields.
REQ-016 INIT: ram_rst=1 for exactly one cycle, then IDLE; when INIT_CLEAR=0, INIT goes to IDLE with ram_rst=0.
REQ-017 IDLE, no req: stay; all ram enables=0.
REQ-018 IDLE, req pending: arbitrate; latch winner id, wr, addr, wdata; go to WRITE if wr=1, else READ.
REQ-019 Round-robin: a single req wins unconditionally; if both are high, the requester named by pointer prio wins; prio is set to the loser after every grant; prio resets to A.
REQ-020 WRITE: ram_we=1, ram_wr_add=latched addr, ram_datain=latched wdata, ram_re=0; next state DONE.
REQ-021 READ: ram_re=1, ram_we=0, ram_rd_add=latched addr; next state RCAP.
REQ-022 RCAP: all enables 0; on exit, load ram_dataout into the winner's rdata register; next state DONE.
REQ-023 DONE: winner's ack=1 for one cycle, the other ack=0; next state IDLE.
REQ-024 Latency, grant in IDLE at cycle N: write sees ram_we at N+1 and ack at N+2; read sees ram_re at N+1 and ack with rdata at N+3.
REQ-025 ram_we and ram_re SHALL never be high together (the RAM prioritises we and would drop the read).
REQ-026 Requester protocol: deassert req no later than the edge after ack; req still high in IDLE after DONE is a new transaction.
REQ-027 A req arriving while busy=1 waits; it is evaluated only in IDLE, with no loss.
REQ-028 Address/data change while req is high and not yet granted: the value sampled at the grant edge is used.
REQ-029 Read of a never-written address after a clear returns 8'h00.
REQ-030 Idle outputs: ram_wr_add, ram_rd_add and ram_datain hold their last latched values; enables are 0.

Reset
REQ-031 rst=0 at any time, including mid-transaction: state=INIT, prio=A, ack_a=ack_b=0, rdata_a=rdata_b=8'h00, busy=1, ram_we=ram_re=0, latched fields=0, ram_rst=INIT_CLEAR; the in-flight transaction is abandoned with no ack.
REQ-032 After reset release, the first grant is possible one cycle after INIT (IDLE).

Verification
REQ-033 Reset release, then A writes addr 3 = 8'hA5, then A reads addr 3 -> ram_rst pulse 1 cycle; write ack 2 cycles after grant; read ack with rdata_a=8'hA5 3 cycles after grant.
REQ-034 req_a and req_b rise in the same IDLE cycle (A wr addr 1=8'h11, B wr addr 2=8'h22), held for 4 rounds -> grants alternate A,B,A,B; never two consecutive grants to one requester while both request.
REQ-035 B reads addr 7 before any write after clear -> rdata_b=8'h00; rdata_a unchanged.
REQ-036 rst pulsed low during READ state -> no ack; outputs match REQ-031; the next transaction completes normally.
REQ-037 Continuous random traffic, 1000 transactions checked against a 16-entry reference model -> every read matches the last write; ram_we & ram_re never both 1; exactly one ack per grant.
REQ-038 INIT_CLEAR=0 -> ram_rst never asserted; first grant in the cycle after reset release.
